uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter ADDR_LEN, default 32, meaning width of the load address output.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_x  input  1  reset, asynchronous and active-low.
REQ-005 rxd  input  1  UART serial input, 8N1, idle high, asynchronous to clk.
REQ-006 addr  output  ADDR_LEN  byte address of the word currently being written.
REQ-007 data  output  128  load data line; newest 32-bit word in [127:96].
REQ-008 we_32  output  1  one-cycle dmem word write strobe.
REQ-009 we_128  output  1  one-cycle imem line write strobe.
REQ-010 done  output  1  sticky; load complete.
REQ-011 err  output  1  sticky; at least one framing error seen.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer before any use, reset value 1.
REQ-013 Receiver FSM states: IDLE, START, BITS, STOP.
REQ-014 IDLE: synchronized rxd low -> START, bit counter cleared.
REQ-015 START: at CLKS_PER_BIT/2 cycles, rxd low -> BITS; rxd high -> IDLE (glitch, no byte, no err).
REQ-016 BITS: sample every CLKS_PER_BIT cycles, LSB first, 8 bits, then -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles sample; high -> byte valid one cycle; low -> byte discarded, err set; either way -> IDLE.
REQ-018 Loader FSM states: HDR, DATA, FIN.
REQ-019 HDR: first 4 valid bytes form line count L, little-endian 32-bit.
REQ-020 HDR with L=0: -> FIN, done asserted next cycle, no write strobes.
REQ-021 HDR with L>0: -> DATA, byte offset cleared to 0.
REQ-022 DATA: every 4 bytes assemble a little-endian word W.
REQ-023 On each word, data SHALL shift {W, data[127:32]} and we_32 SHALL pulse for one cycle.
REQ-024 On each word, addr SHALL equal that word's byte offset from 0.
REQ-025 On every 4th word, we_128 SHALL pulse in the same cycle as we_32, with addr = line base + 12; lane 0 is in data[31:0].
REQ-026 Strobe latency: we_32/we_128 SHALL assert the cycle after the STOP-valid of the word's last byte.
REQ-027 After L lines written -> FIN; done asserts the cycle after the final we_128.
REQ-028 FIN: all further bytes ignored; done stays high until reset.
REQ-029 A framing error SHALL NOT advance byte/word/line counters; the bad byte is simply lost.
REQ-030 Counters SHALL be wide enough for L up to 2^28 without wrap; addr truncates to ADDR_LEN.

Reset
REQ-031 reset_x low SHALL asynchronously clear everything: FSMs to IDLE/HDR; addr, data, we_32, we_128, done, err, counters to 0; synchronizer to 1.
REQ-032 Reset mid-frame or mid-load SHALL abandon partial bytes/words; after release, the next byte starts a fresh header.

Structure
REQ-033 FSM state encodings and the 8N1 frame constants SHALL live in a shared package.
REQ-034 Sub-module uart_rx (synchronizer plus receiver FSM; byte and valid out) SHALL be instantiated by the loader FSM.

Verification (CLKS_PER_BIT=8)
REQ-035 Header 01 00 00 00, then bytes 00..0F -> we_32 at addr 0,4,8,12; data[127:96] = 03020100, 07060504, 0B0A0908, 0F0E0D0C; we_128 with addr 12 and data = 0F0E0D0C_0B0A0908_07060504_03020100; done the next cycle.
REQ-036 Header 00 00 00 00 -> done with no strobes; following byte AA -> no effect.
REQ-037 Byte 0x55 with stop bit low inside the data stream -> err=1, no strobe; byte resent correctly -> load completes with correct data.
REQ-038 rxd low pulse of 2 cycles -> no byte, err=0, FSM back to IDLE.
REQ-039 Header L=2, then 32 bytes -> second we_128 at addr 28.
REQ-039a reset_x pulsed low after 10 of 32 data bytes, then header L=1 plus 16 bytes -> only the new load is written, starting at addr 0.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader_pkg
// Brief    : Shared FSM encodings, 8N1 frame constants and byte-assembly helper
// Revision : 1.0
// ============================================================================
package uart_prog_loader_pkg;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic FRAME_IDLE_LVL  = 1'b1;
    localparam logic FRAME_START_LVL = 1'b0;
    localparam logic FRAME_STOP_LVL  = 1'b1;

    localparam int WORD_BYTES = 4;
    localparam int LINE_WORDS = 4;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        LD_HDR  = 2'd0,
        LD_DATA = 2'd1,
        LD_FIN  = 2'd2
    } ld_state_e;

    // Bytes arrive LSB-first, so each new byte enters at the top and the oldest
    // byte ends up in [7:0] once the word is complete.
    function automatic logic [31:0] le_push(input logic [31:0] word, input logic [7:0] b);
        return {b, word[31:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader_if
// Brief    : Memory-load bus driven by the loader toward imem/dmem
// Revision : 1.0
// ============================================================================
interface uart_prog_loader_if #(
    parameter int ADDR_LEN = 32
);
    logic [ADDR_LEN-1:0] addr;
    logic [127:0]        data;
    logic                we_32;
    logic                we_128;
    logic                done;
    logic                err;

    modport master (
        output addr,
        output data,
        output we_32,
        output we_128,
        output done,
        output err
    );

    modport slave (
        input addr,
        input data,
        input we_32,
        input we_128,
        input done,
        input err
    );
endinterface
`default_nettype wire

// File: rtl/uart_prog_loader_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with 2-flop input synchronizer
// Revision : 1.0
// ============================================================================
module uart_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_x,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] C_FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       C_BIT_LAST  = 3'(FRAME_DATA_BITS - 1);

    logic [1:0]       sync_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             rxd_s;

    assign rxd_s = sync_q[1];

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            sync_q      <= {2{FRAME_IDLE_LVL}};
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rxd_i};
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (rxd_s == FRAME_START_LVL) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                RX_START: begin
                    // Mid-start-bit recheck rejects short line glitches.
                    if (cnt_q == C_HALF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (rxd_s == FRAME_START_LVL) ? RX_BITS : RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (cnt_q == C_FULL_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rxd_s, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == C_BIT_LAST) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == C_FULL_LAST) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rxd_s == FRAME_STOP_LVL) begin
                            byte_o  <= shift_q;
                            valid_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader
// Brief    : UART program loader: header line count, then 32b/128b write strobes
// Revision : 1.0
// ============================================================================
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_LEN     = 32
) (
    input  logic               clk,
    input  logic               reset_x,
    input  logic               rxd,
    uart_prog_loader_if.master ld
);

    localparam logic [1:0] C_BYTE_LAST = 2'(WORD_BYTES - 1);
    localparam logic [1:0] C_WORD_LAST = 2'(LINE_WORDS - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .reset_x     (reset_x),
        .rxd_i       (rxd),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    ld_state_e    state_q;
    logic [1:0]   byte_cnt_q;
    logic [1:0]   word_cnt_q;
    logic [31:0]  asm_q;
    logic [31:0]  line_total_q;
    logic [31:0]  lines_done_q;
    logic [31:0]  off_q;
    logic [31:0]  addr_q;
    logic [127:0] data_q;
    logic         we32_q;
    logic         we128_q;
    logic         done_q;
    logic         err_q;
    logic [31:0]  word_d;

    assign word_d = le_push(asm_q, rx_byte);

    // 32-bit offsets reach 2^32-4 at L = 2^28 lines, so nothing wraps.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q      <= LD_HDR;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            asm_q        <= '0;
            line_total_q <= '0;
            lines_done_q <= '0;
            off_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            we32_q       <= 1'b0;
            we128_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            we32_q  <= 1'b0;
            we128_q <= 1'b0;
            if (rx_ferr) begin
                err_q <= 1'b1;
            end
            case (state_q)
                LD_HDR: begin
                    if (rx_valid) begin
                        asm_q      <= word_d;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q == C_BYTE_LAST) begin
                            line_total_q <= word_d;
                            if (word_d == '0) begin
                                state_q <= LD_FIN;
                                done_q  <= 1'b1;
                            end else begin
                                state_q      <= LD_DATA;
                                off_q        <= '0;
                                word_cnt_q   <= '0;
                                lines_done_q <= '0;
                            end
                        end
                    end
                end
                LD_DATA: begin
                    if (rx_valid) begin
                        asm_q      <= word_d;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q == C_BYTE_LAST) begin
                            data_q     <= {word_d, data_q[127:32]};
                            addr_q     <= off_q;
                            off_q      <= off_q + 32'd4;
                            we32_q     <= 1'b1;
                            word_cnt_q <= word_cnt_q + 1'b1;
                            if (word_cnt_q == C_WORD_LAST) begin
                                we128_q      <= 1'b1;
                                lines_done_q <= lines_done_q + 32'd1;
                                if (lines_done_q + 32'd1 == line_total_q) begin
                                    state_q <= LD_FIN;
                                end
                            end
                        end
                    end
                end
                LD_FIN: done_q <= 1'b1;
                default: state_q <= LD_HDR;
            endcase
        end
    end

    assign ld.addr   = ADDR_LEN'(addr_q);
    assign ld.data   = data_q;
    assign ld.we_32  = we32_q;
    assign ld.we_128 = we128_q;
    assign ld.done   = done_q;
    assign ld.err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_prog_loader
// Brief    : Scoreboard bench: byte-stream reference model vs loader strobes
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int CPB = 8;
    localparam int AL  = 32;

    logic clk     = 1'b0;
    logic reset_x = 1'b0;
    logic rxd     = 1'b1;

    always #5 clk = ~clk;

    uart_prog_loader_if #(.ADDR_LEN(AL)) ld_if ();

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_LEN    (AL)
    ) dut (
        .clk     (clk),
        .reset_x (reset_x),
        .rxd     (rxd),
        .ld      (ld_if)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  word;
        bit           line;
        logic [127:0] line_data;
        bit           last;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    byte unsigned hdr_b[$];
    byte unsigned dat_b[$];
    logic [31:0]  m_words[$];
    longint       m_L;
    bit           m_fin;
    bit           m_err;
    bit           chk_done_next = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        hdr_b.delete();
        dat_b.delete();
        m_words.delete();
        m_L   = 0;
        m_fin = 1'b0;
        m_err = 1'b0;
    endfunction

    // Reference: header = first 4 good bytes (LE line count), then each 4 good
    // bytes form a word at offset 4*index; every 4th word completes a line.
    function automatic void model_byte(input byte unsigned b, input bit ok);
        if (!ok) begin
            m_err = 1'b1;
            return;
        end
        if (m_fin) return;
        if (hdr_b.size() < 4) begin
            hdr_b.push_back(b);
            if (hdr_b.size() == 4) begin
                m_L = longint'(hdr_b[0]) + (longint'(hdr_b[1]) << 8) +
                      (longint'(hdr_b[2]) << 16) + (longint'(hdr_b[3]) << 24);
                if (m_L == 0) m_fin = 1'b1;
            end
            return;
        end
        dat_b.push_back(b);
        if (dat_b.size() % 4 == 0) begin
            int          n;
            int          k;
            logic [31:0] w;
            exp_t        e;
            n = dat_b.size();
            w = {dat_b[n-1], dat_b[n-2], dat_b[n-3], dat_b[n-4]};
            m_words.push_back(w);
            k           = m_words.size();
            e.addr      = 32'(4 * (k - 1));
            e.word      = w;
            e.line      = (k % 4 == 0);
            e.line_data = '0;
            e.last      = 1'b0;
            if (e.line) begin
                e.line_data = {m_words[k-1], m_words[k-2], m_words[k-3], m_words[k-4]};
                if (longint'(k / 4) == m_L) begin
                    e.last = 1'b1;
                    m_fin  = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
    endfunction

    task automatic hold(input bit v, input int cyc);
        rxd = v;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic send_byte(input byte unsigned b, input bit ok = 1'b1);
        model_byte(b, ok);
        @(negedge clk);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(ok, CPB);
        hold(1'b1, 2 * CPB);
    endtask

    task automatic send_header(input int lines);
        for (int i = 0; i < 4; i++) send_byte(8'(lines >> (8 * i)));
    endtask

    task automatic random_load(input int lines, input int bad_left);
        byte unsigned b;
        send_header(lines);
        for (int i = 0; i < 16 * lines; i++) begin
            b = 8'($urandom_range(0, 255));
            if (bad_left > 0 && $urandom_range(0, 7) == 0) begin
                send_byte(b, 1'b0);
                bad_left--;
            end
            send_byte(b);
        end
    endtask

    task automatic phase_end(input string name);
        repeat (4 * CPB) @(negedge clk);
        check({name, "_pending"}, 128'(exp_q.size()), 128'd0);
        check({name, "_done"}, ld_if.done, m_fin);
        check({name, "_err"}, ld_if.err, m_err);
    endtask

    task automatic apply_reset();
        reset_x = 1'b0;
        rxd     = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        exp_q.delete();
        chk_done_next = 1'b0;
        reset_x = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every strobe consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset_x) begin
            if (chk_done_next) begin
                check("done_after_last_line", ld_if.done, 1'b1);
                chk_done_next = 1'b0;
            end
            if (ld_if.we_32 || ld_if.we_128) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {ld_if.we_32, ld_if.we_128}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("we_32", ld_if.we_32, 1'b1);
                    check("addr", ld_if.addr, e.addr);
                    check("data_hi", ld_if.data[127:96], e.word);
                    check("we_128", ld_if.we_128, e.line);
                    if (e.line) check("line_data", ld_if.data, e.line_data);
                    check("done_during_load", ld_if.done, 1'b0);
                    if (e.last) chk_done_next = 1'b1;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        byte unsigned b;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_addr", ld_if.addr, 0);
        check("rst_data", ld_if.data, 0);
        check("rst_we_32", ld_if.we_32, 0);
        check("rst_we_128", ld_if.we_128, 0);
        check("rst_done", ld_if.done, 0);
        check("rst_err", ld_if.err, 0);
        reset_x = 1'b1;
        repeat (2) @(negedge clk);

        // Single line of 00..0F
        send_header(1);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        phase_end("basic");
        send_byte(8'hAA);
        phase_end("fin_ignore");

        // Empty load
        apply_reset();
        send_header(0);
        phase_end("empty_hdr");
        send_byte(8'hAA);
        phase_end("empty_after");

        // Bad-stop 0x55 then the same byte resent
        apply_reset();
        send_header(1);
        p = $urandom_range(0, 15);
        for (int i = 0; i < 16; i++) begin
            b = (i == p) ? 8'h55 : 8'($urandom_range(0, 255));
            if (i == p) send_byte(8'h55, 1'b0);
            send_byte(b);
        end
        phase_end("framing");

        // Short low glitch
        apply_reset();
        @(negedge clk);
        hold(1'b0, 2);
        hold(1'b1, 4 * CPB);
        check("glitch_err", ld_if.err, 1'b0);
        check("glitch_idle", dut.u_rx.state_q, RX_IDLE);
        random_load(1, 0);
        phase_end("post_glitch");

        // Two lines
        apply_reset();
        random_load(2, 0);
        phase_end("two_lines");

        // Reset mid-load and mid-frame
        apply_reset();
        send_header(2);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
        phase_end("pre_reset");
        @(negedge clk);
        hold(1'b0, 3 * CPB);
        #2 reset_x = 1'b0;
        #1;
        check("async_addr", ld_if.addr, 0);
        check("async_data", ld_if.data, 0);
        rxd = 1'b1;
        model_reset();
        exp_q.delete();
        chk_done_next = 1'b0;
        repeat (3) @(negedge clk);
        reset_x = 1'b1;
        repeat (2) @(negedge clk);
        random_load(1, 0);
        phase_end("after_reset");

        // Randomized loads with occasional framing errors
        for (int r = 0; r < 3; r++) begin
            apply_reset();
            random_load($urandom_range(1, 3), $urandom_range(0, 2));
            send_byte(8'($urandom_range(0, 255)));
            phase_end("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
